// File: rtl/seg_scan_driver.sv
// Six-digit common-anode 7-segment scan driver with per-frame input snapshot.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_scan_driver #(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [23:0] digit_ctrl,
    output logic [7:0]  seg,
    output logic [5:0]  an,
    output logic        frame_tick
);

    localparam int unsigned   DW        = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DIV_LAST  = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DIV_BLANK = DW'(BLANK_CYC);

    logic [DW-1:0] div;
    logic [2:0]    idx;
    logic [23:0]   snap;

    logic [3:0]    nib;
    logic [6:0]    glyph;
    logic          hide;
    logic          lit;
    logic [5:0]    an_nxt;
    logic [7:0]    seg_nxt;

    always_comb begin
        nib = snap[3:0];
        case (idx)
            3'd0:    nib = snap[3:0];
            3'd1:    nib = snap[7:4];
            3'd2:    nib = snap[11:8];
            3'd3:    nib = snap[15:12];
            3'd4:    nib = snap[19:16];
            3'd5:    nib = snap[23:20];
            default: nib = snap[3:0];
        endcase
    end

    // Active-low {g,f,e,d,c,b,a}
    always_comb begin
        glyph = 7'h7F;
        case (nib)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            4'hF: glyph = 7'h0E;
            default: glyph = 7'h7F;
        endcase
    end

`ifdef SEG_LZB_EN
    // lz[k]: nibbles 5..k of the snapshot are all zero; digit 0 is never hidden
    logic [7:0] lz;
    always_comb begin
        lz    = '0;
        lz[5] = (snap[23:20] == 4'h0);
        lz[4] = lz[5] && (snap[19:16] == 4'h0);
        lz[3] = lz[4] && (snap[15:12] == 4'h0);
        lz[2] = lz[3] && (snap[11:8]  == 4'h0);
        lz[1] = lz[2] && (snap[7:4]   == 4'h0);
        hide  = lz[idx];
    end
`else
    assign hide = 1'b0;
`endif

    always_comb begin
        lit     = en && (div >= DIV_BLANK) && !hide;
        an_nxt  = lit ? ~(6'(1) << idx) : '1;
        seg_nxt = lit ? {1'b1, glyph} : '1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div        <= '0;
            idx        <= '0;
            snap       <= '0;
            an         <= '1;
            seg        <= '1;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_nxt;
            seg        <= seg_nxt;
            frame_tick <= en && (idx == 3'd5) && (div == DIV_LAST);
            if (!en) begin
                div <= '0;
                idx <= '0;
            end else begin
                // Snapshot lands inside the blanking window of slot 0
                if (idx == 3'd0 && div == '0)
                    snap <= digit_ctrl;
                if (div == DIV_LAST) begin
                    div <= '0;
                    idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
                end else begin
                    div <= div + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized bench for seg_scan_driver (SCAN_DIV=4, BLANK_CYC=1) against a frame-position model.
module tb_seg_scan_driver;

    localparam int SD    = 4;
    localparam int BC    = 1;
    localparam int FRAME = 6 * SD;
    localparam logic [6:0] DEC [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [23:0] digit_ctrl = '0;
    logic [7:0]  seg;
    logic [5:0]  an;
    logic        frame_tick;

    int n_cmp = 0;
    int n_bad = 0;

    seg_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .digit_ctrl (digit_ctrl),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Model: position within the frame counted in enabled cycles since restart
    int          pos  = 0;
    logic [23:0] msnap = '0;
    logic [5:0]  exp_an   = '1;
    logic [7:0]  exp_seg  = '1;
    logic        exp_tick = 1'b0;

    function automatic logic suppressed(input logic [23:0] s, input int slot);
`ifdef SEG_LZB_EN
        return (slot > 0) && ((s >> (4 * slot)) == 24'h0);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin
        int   slot;
        logic on;
        slot = pos / SD;
        on   = en && ((pos % SD) >= BC) && !suppressed(msnap, slot);
        if (rst) begin
            pos      <= 0;
            msnap    <= '0;
            exp_an   <= '1;
            exp_seg  <= '1;
            exp_tick <= 1'b0;
        end else begin
            exp_an   <= on ? ~(6'(1) << slot) : 6'h3F;
            exp_seg  <= on ? {1'b1, DEC[msnap[slot*4 +: 4]]} : 8'hFF;
            exp_tick <= en && (pos == FRAME - 1);
            if (!en) pos <= 0;
            else begin
                if (pos == 0) msnap <= digit_ctrl;
                pos <= (pos + 1) % FRAME;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; digit_ctrl = 24'h987654;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({an, seg, frame_tick} !== {6'h3F, 8'hFF, 1'b0}) begin
                n_bad++;
                $display("FAIL reset cyc%0d an=%h seg=%h tick=%b exp an=3f seg=ff tick=0", i, an, seg, frame_tick);
            end
        end
        rst = 1'b0; en = 1'b0;
    endtask

    task automatic test_scan();
        int ticks = 0;
        en = 1'b1; digit_ctrl = 24'h123456;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            ticks += frame_tick;
            n_cmp++;
            if ({an, seg, frame_tick} !== {exp_an, exp_seg, exp_tick}) begin
                n_bad++;
                $display("FAIL scan cyc%0d an=%h seg=%h tick=%b exp an=%h seg=%h tick=%b",
                         i, an, seg, frame_tick, exp_an, exp_seg, exp_tick);
            end
        end
        n_cmp++;
        if (ticks != 2) begin
            n_bad++;
            $display("FAIL scan_tick_count got=%0d exp=2", ticks);
        end
    endtask

    task automatic test_snapshot();
        // Move to mid slot 2 then change the input
        while (pos != 2 * SD + 1) @(negedge clk);
        digit_ctrl = 24'hABCDEF;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({an, seg, frame_tick} !== {exp_an, exp_seg, exp_tick}) begin
                n_bad++;
                $display("FAIL snapshot cyc%0d an=%h seg=%h tick=%b exp an=%h seg=%h tick=%b",
                         i, an, seg, frame_tick, exp_an, exp_seg, exp_tick);
            end
        end
    endtask

    task automatic test_en_toggle();
        while (pos != 3 * SD + 2) @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 2 * FRAME + 8; i++) begin
            @(negedge clk);
            if (i == 6) begin
                en = 1'b1;
                digit_ctrl = 24'($urandom);
            end
            n_cmp++;
            if ({an, seg, frame_tick} !== {exp_an, exp_seg, exp_tick}) begin
                n_bad++;
                $display("FAIL en_toggle cyc%0d an=%h seg=%h tick=%b exp an=%h seg=%h tick=%b",
                         i, an, seg, frame_tick, exp_an, exp_seg, exp_tick);
            end
        end
    endtask

    task automatic test_rst_mid();
        while (pos != 4 * SD + 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({an, seg, frame_tick} !== {6'h3F, 8'hFF, 1'b0}) begin
            n_bad++;
            $display("FAIL rst_mid an=%h seg=%h tick=%b exp an=3f seg=ff tick=0", an, seg, frame_tick);
        end
        rst = 1'b0; digit_ctrl = 24'h0F1E2D;
        for (int i = 0; i < FRAME + 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({an, seg, frame_tick} !== {exp_an, exp_seg, exp_tick}) begin
                n_bad++;
                $display("FAIL rst_restart cyc%0d an=%h seg=%h tick=%b exp an=%h seg=%h tick=%b",
                         i, an, seg, frame_tick, exp_an, exp_seg, exp_tick);
            end
        end
    endtask

    task automatic test_sweep();
        logic [31:0] r;
        for (int code = 0; code < 16; code++) begin
            r = $urandom;
            digit_ctrl = {r[19:0], 4'(code)};
            for (int i = 0; i < FRAME; i++) begin
                @(negedge clk);
                n_cmp++;
                if ({an, seg, frame_tick} !== {exp_an, exp_seg, exp_tick} || seg[7] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL sweep code%0d cyc%0d an=%h seg=%h tick=%b exp an=%h seg=%h tick=%b",
                             code, i, an, seg, frame_tick, exp_an, exp_seg, exp_tick);
                end
            end
        end
    endtask

    task automatic test_leading_zeros();
        logic [23:0] pats [2] = '{24'h000120, 24'h000000};
        for (int p = 0; p < 2; p++) begin
            digit_ctrl = pats[p];
            for (int i = 0; i < 2 * FRAME; i++) begin
                @(negedge clk);
                n_cmp++;
                if ({an, seg, frame_tick} !== {exp_an, exp_seg, exp_tick}) begin
                    n_bad++;
                    $display("FAIL lzb pat%0d cyc%0d an=%h seg=%h tick=%b exp an=%h seg=%h tick=%b",
                             p, i, an, seg, frame_tick, exp_an, exp_seg, exp_tick);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] r;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({an, seg, frame_tick} !== {exp_an, exp_seg, exp_tick}
                || $countones(~an) > 1 || (an != 6'h3F && seg == 8'hFF)) begin
                n_bad++;
                $display("FAIL random cyc%0d an=%h seg=%h tick=%b exp an=%h seg=%h tick=%b",
                         i, an, seg, frame_tick, exp_an, exp_seg, exp_tick);
            end
            r   = $urandom;
            rst = (r[6:0] == 7'd0);
            en  = (r[11:7] != 5'd0);
            if (r[15:12] == 4'd0) digit_ctrl = 24'($urandom);
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_snapshot();
        test_en_toggle();
        test_rst_mid();
        test_sweep();
        test_leading_zeros();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout compared=%0d", n_cmp);
        $fatal(1);
    end

endmodule
